// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one TX UART byte FIFO between
// NUM_REQ byte-stream requesters, with a mid-packet stall timeout.
module uart_tx_arbiter #(
   parameter int unsigned          NUM_REQ  = 4,
   parameter int unsigned          TO_WIDTH = 16,
   parameter logic [TO_WIDTH-1:0]  TIMEOUT  = 16'd50000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [7:0]             o_uart_din,
   output logic                   o_uart_valid,
   input  logic                   i_uart_full,
   output logic [NUM_REQ-1:0]     o_grant,
   output logic                   o_busy,
   output logic                   o_timeout
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    owner;
   logic [IDX_W-1:0]    last_owner;
   logic [IDX_W-1:0]    pick;
   logic [IDX_W-1:0]    cand;
   logic                pick_found;
   logic [TO_WIDTH-1:0] to_cnt;
   logic [TO_WIDTH-1:0] cnt_inc;
   logic                timeout_hit;
   logic                accept;

   // Search upward from the slot after the previous owner, wrapping at NUM_REQ.
   always_comb begin
      pick       = '0;
      cand       = '0;
      pick_found = 1'b0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((32'(last_owner) + i) % NUM_REQ);
         if (!pick_found && req_valid[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready    = '0;
      o_uart_valid = 1'b0;
      o_uart_din   = req_data[{owner, 3'b000} +: 8];
      if (state == XFER) begin
         req_ready[owner] = !i_uart_full;
         o_uart_valid     = req_valid[owner] && !i_uart_full;
      end
   end

   assign accept      = o_uart_valid;
   assign cnt_inc     = (&to_cnt) ? to_cnt : to_cnt + TO_WIDTH'(1);
   assign timeout_hit = (TIMEOUT != '0) && (cnt_inc == TIMEOUT);
   assign o_busy      = (state == XFER);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= IDX_W'(NUM_REQ - 1);
         o_grant    <= '0;
         o_timeout  <= 1'b0;
         to_cnt     <= '0;
      end else begin
         o_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state   <= XFER;
                  owner   <= pick;
                  o_grant <= NUM_REQ'(1) << pick;
                  to_cnt  <= '0;
               end
            end
            XFER: begin
               if (accept) begin
                  to_cnt <= '0;
                  if (req_last[owner]) begin
                     state      <= IDLE;
                     o_grant    <= '0;
                     last_owner <= owner;
                  end
               end else begin
                  // The pulse and the release land on the edge where the
                  // stall count reaches TIMEOUT, so the owner loses the bus.
                  to_cnt <= cnt_inc;
                  if (timeout_hit) begin
                     o_timeout  <= 1'b1;
                     state      <= IDLE;
                     o_grant    <= '0;
                     last_owner <= owner;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle comparison against a
// transaction-level model plus literal checks on logged write/grant events.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int TO = 20;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [8*NR-1:0] req_data = '0;
   logic [NR-1:0]   req_valid = '0;
   logic [NR-1:0]   req_last = '0;
   logic [NR-1:0]   req_ready;
   logic [7:0]      o_uart_din;
   logic            o_uart_valid;
   logic            i_uart_full = 1'b0;
   logic [NR-1:0]   o_grant;
   logic            o_busy;
   logic            o_timeout;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Per-requester byte sources: {last, data}
   logic [8:0] q [NR][$];
   logic [NR-1:0] pop = '0;

   // Event logs taken from the DUT pins
   logic [7:0]    wr_byte [$];
   int            wr_cyc  [$];
   logic [NR-1:0] gr_val  [$];
   int            gr_cyc  [$];
   int            to_cyc  [$];
   logic [NR-1:0] prev_grant = '0;

   // Model: current owner (-1 idle), previous owner, stall cycles, pulse flag
   int m_owner = -1;
   int m_last  = NR - 1;
   int m_since = 0;
   bit m_to    = 1'b0;

   uart_tx_arbiter #(
      .NUM_REQ  (NR),
      .TO_WIDTH (16),
      .TIMEOUT  (16'd20)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_data     (req_data),
      .req_valid    (req_valid),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .o_uart_din   (o_uart_din),
      .o_uart_valid (o_uart_valid),
      .i_uart_full  (i_uart_full),
      .o_grant      (o_grant),
      .o_busy       (o_busy),
      .o_timeout    (o_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic drive();
      logic [8:0] e;
      for (int k = 0; k < NR; k++) begin
         if (q[k].size() > 0) begin
            e                  = q[k][0];
            req_valid[k]       = 1'b1;
            req_last[k]        = e[8];
            req_data[8*k +: 8] = e[7:0];
         end else begin
            req_valid[k]       = 1'b0;
            req_last[k]        = 1'b0;
            req_data[8*k +: 8] = 8'h00;
         end
      end
   endtask

   task automatic push(input int k, input logic [7:0] b, input logic last);
      q[k].push_back({last, b});
   endtask

   task automatic clear_logs();
      wr_byte.delete(); wr_cyc.delete();
      gr_val.delete();  gr_cyc.delete();
      to_cyc.delete();
   endtask

   task automatic clear_srcs();
      for (int k = 0; k < NR; k++) q[k].delete();
      drive();
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_grant"},  32'(o_grant),      32'h0);
      chk({tag, "_busy"},   32'(o_busy),       32'h0);
      chk({tag, "_tmo"},    32'(o_timeout),    32'h0);
      chk({tag, "_ready"},  32'(req_ready),    32'h0);
      chk({tag, "_uvalid"}, 32'(o_uart_valid), 32'h0);
   endtask

   // Source side: consume bytes the DUT took on the previous edge.
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < NR; k++)
         if (pop[k] && q[k].size() > 0) void'(q[k].pop_front());
      drive();
   end

   // Compare process: check against the model, log events, advance model.
   always @(negedge clk) begin : cmp
      logic [NR-1:0] e_ready;
      logic [NR-1:0] e_grant;
      logic          e_valid;
      logic          found;
      if (!reset_n) begin
         m_owner    = -1;
         m_last     = NR - 1;
         m_since    = 0;
         m_to       = 1'b0;
         pop        = '0;
         prev_grant = '0;
      end else begin
         e_ready = '0;
         e_grant = '0;
         e_valid = 1'b0;
         if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_ready[m_owner] = !i_uart_full;
            e_valid          = req_valid[m_owner] && !i_uart_full;
         end
         chk("req_ready",  32'(req_ready),    32'(e_ready));
         chk("uart_valid", 32'(o_uart_valid), 32'(e_valid));
         chk("grant",      32'(o_grant),      32'(e_grant));
         chk("busy",       32'(o_busy),       32'(m_owner >= 0));
         chk("timeout",    32'(o_timeout),    32'(m_to));
         if (e_valid) chk("uart_din", 32'(o_uart_din), 32'(req_data[8*m_owner +: 8]));

         if (o_uart_valid) begin
            wr_byte.push_back(o_uart_din);
            wr_cyc.push_back(cyc);
         end
         if (o_timeout) to_cyc.push_back(cyc);
         if (o_grant != '0 && prev_grant == '0) begin
            gr_val.push_back(o_grant);
            gr_cyc.push_back(cyc);
         end
         prev_grant = o_grant;
         pop = req_valid & req_ready;

         m_to = 1'b0;
         if (m_owner < 0) begin
            found = 1'b0;
            for (int i = 1; i <= NR; i++) begin
               if (!found && req_valid[(m_last + i) % NR]) begin
                  m_owner = (m_last + i) % NR;
                  m_since = 0;
                  found   = 1'b1;
               end
            end
         end else if (e_valid) begin
            m_since = 0;
            if (req_last[m_owner]) begin
               m_last  = m_owner;
               m_owner = -1;
            end
         end else begin
            if (m_since < 65535) m_since++;
            if (TO != 0 && m_since == TO) begin
               m_to    = 1'b1;
               m_last  = m_owner;
               m_owner = -1;
            end
         end
      end
   end

   logic [7:0]    t2_bytes [10] = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32, 8'h05, 8'h06};
   logic [NR-1:0] t2_grants [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [7:0]    t5_bytes [4]  = '{8'hC1, 8'hC2, 8'hC3, 8'hD1};
   logic [7:0]    t6_bytes [4]  = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};

   initial begin : main
      int p;
      #1;
      chk_reset_outputs("rst0");
      wait_cyc(3);
      reset_n = 1'b1;

      // Single 3-byte packet from requester 0
      wait_cyc(1);
      clear_logs();
      p = cyc;
      push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
      drive();
      wait_cyc(8);
      chk("t1_ngrant",  32'(gr_val.size()), 32'd1);
      chk("t1_grant",   32'(gr_val[0]), 32'b0001);
      chk("t1_latency", 32'(gr_cyc[0] - p), 32'd1);
      chk("t1_nbytes",  32'(wr_byte.size()), 32'd3);
      for (int i = 0; i < 3; i++) chk("t1_byte", 32'(wr_byte[i]), 32'h41 + 32'(i));
      chk("t1_burst",   32'(wr_cyc[2] - wr_cyc[0]), 32'd2);
      chk("t1_idle_grant", 32'(o_grant), 32'h0);
      chk("t1_idle_busy",  32'(o_busy),  32'h0);

      // All four requesters with 2-byte packets, starting from reset priority
      reset_n = 1'b0;
      clear_srcs();
      wait_cyc(2);
      reset_n = 1'b1;
      wait_cyc(1);
      clear_logs();
      push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1); push(0, 8'h05, 1'b0); push(0, 8'h06, 1'b1);
      push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
      push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
      push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b1);
      drive();
      wait_cyc(20);
      chk("t2_nbytes", 32'(wr_byte.size()), 32'd10);
      for (int i = 0; i < 10; i++) chk("t2_byte", 32'(wr_byte[i]), 32'(t2_bytes[i]));
      for (int i = 0; i < 5; i++)  chk("t2_order", 32'(gr_val[i]), 32'(t2_grants[i]));
      chk("t2_bubble", 32'(wr_cyc[2] - wr_cyc[1]), 32'd2);

      // UART full for 10 cycles mid-packet; owner is requester 1
      clear_logs();
      push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
      drive();
      wait_cyc(1);
      wait_cyc(1);
      i_uart_full = 1'b1;
      wait_cyc(10);
      i_uart_full = 1'b0;
      wait_cyc(6);
      chk("t3_grant",  32'(gr_val[0]), 32'b0010);
      chk("t3_ngrant", 32'(gr_val.size()), 32'd1);
      chk("t3_stall",  32'(wr_cyc[1] - wr_cyc[0]), 32'd11);
      chk("t3_byte3",  32'(wr_byte[2]), 32'hA3);

      // Owner 2 stalls after one byte; requester 3 is waiting
      clear_logs();
      push(2, 8'h77, 1'b0);
      push(3, 8'h88, 1'b1);
      drive();
      wait_cyc(30);
      chk("t4_ntmo",    32'(to_cyc.size()), 32'd1);
      // Pulse rises on the 20th edge after the accepting edge.
      chk("t4_tmo_gap", 32'(to_cyc[0] - wr_cyc[0]), 32'd21);
      chk("t4_next",    32'(gr_val[1]), 32'b1000);
      chk("t4_next_at", 32'(gr_cyc[1] - to_cyc[0]), 32'd1);
      chk("t4_byte",    32'(wr_byte[1]), 32'h88);

      // Requester 1 waits while requester 2 holds a packet
      clear_logs();
      push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b0); push(2, 8'hC3, 1'b1);
      drive();
      wait_cyc(1);
      push(1, 8'hD1, 1'b1);
      drive();
      wait_cyc(12);
      chk("t5_first",  32'(gr_val[0]), 32'b0100);
      chk("t5_second", 32'(gr_val[1]), 32'b0010);
      for (int i = 0; i < 4; i++) chk("t5_byte", 32'(wr_byte[i]), 32'(t5_bytes[i]));
      chk("t5_bubble", 32'(wr_cyc[3] - wr_cyc[2]), 32'd2);

      // Reset mid-packet, then simultaneous request from all four
      push(3, 8'hF1, 1'b0); push(3, 8'hF2, 1'b0); push(3, 8'hF3, 1'b0); push(3, 8'hF4, 1'b1);
      drive();
      wait_cyc(1);
      wait_cyc(1);
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("rst_mid");
      clear_srcs();
      wait_cyc(2);
      reset_n = 1'b1;
      clear_logs();
      push(0, 8'hE0, 1'b1); push(1, 8'hE1, 1'b1); push(2, 8'hE2, 1'b1); push(3, 8'hE3, 1'b1);
      drive();
      wait_cyc(15);
      chk("t6_first", 32'(gr_val[0]), 32'b0001);
      for (int i = 0; i < 4; i++) chk("t6_byte", 32'(wr_byte[i]), 32'(t6_bytes[i]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
